sc_mem_access_ctrl: RTL and testbench

//  Main-memory access controller between the control unit, the DATAPATH and a synchronous

---
 rtl/sc_mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sc_mem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mem_access_ctrl.sv
// Main-memory access controller: one RAM read or write per request with WAIT_STATES wait cycles.
// Optional access counter output enabled by defining MEMCTRL_ACCESS_COUNT_EN.
module sc_mem_access_ctrl #(
  parameter int unsigned DATAWIDTH_BUS = 32,
  parameter int unsigned ADDRWIDTH_MEM = 10,
  parameter int unsigned WAIT_STATES   = 1
) (
  input  logic                     MEMCTRL_CLOCK_50,
  input  logic                     MEMCTRL_ResetInLow_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_Address_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_WriteData_InBus,
  input  logic                     MEMCTRL_Read_In,
  input  logic                     MEMCTRL_Write_In,
  output logic [DATAWIDTH_BUS-1:0] MEMCTRL_MemoryData_OutBus,
  output logic                     MEMCTRL_Ready_Out,
  output logic                     MEMCTRL_Fault_Out,
  output logic                     MEMCTRL_Busy_Out,
  output logic [ADDRWIDTH_MEM-1:0] MEMCTRL_MemAddr_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEMCTRL_MemWrData_OutBus,
  output logic                     MEMCTRL_MemWrEn_Out,
  output logic                     MEMCTRL_MemRdEn_Out,
`ifdef MEMCTRL_ACCESS_COUNT_EN
  output logic [15:0]              MEMCTRL_AccessCount_OutBus,
`endif
  input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_MemRdData_InBus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     is_wr_q, is_wr_d;
  logic [ADDRWIDTH_MEM-1:0] waddr_q, waddr_d;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
  logic                     ready_q, ready_d;
  logic                     fault_q, fault_d;
  logic                     busy_q, busy_d;
  logic                     wren_q, wren_d;
  logic                     rden_q, rden_d;

  logic req;
  logic addr_bad;

  assign req      = MEMCTRL_Read_In | MEMCTRL_Write_In;
  // Misaligned or beyond the RAM's byte range
  assign addr_bad = (|MEMCTRL_Address_InBus[1:0]) ||
                    ((MEMCTRL_Address_InBus >> (ADDRWIDTH_MEM + 2)) != '0);

  always_ff @(posedge MEMCTRL_CLOCK_50 or negedge MEMCTRL_ResetInLow_In) begin
    if (!MEMCTRL_ResetInLow_In) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req) state_d = addr_bad ? S_DONE : S_ACCESS;
      S_ACCESS:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (!req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (addr_bad) begin
            fault_d = 1'b1;
          end else begin
            waddr_d = MEMCTRL_Address_InBus[ADDRWIDTH_MEM+1:2];
            wdata_d = MEMCTRL_WriteData_InBus;
            is_wr_d = MEMCTRL_Write_In;
            cnt_d   = WaitLoad;
            wren_d  = MEMCTRL_Write_In;
            rden_d  = !MEMCTRL_Write_In;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!is_wr_q) rdata_d = MEMCTRL_MemRdData_InBus;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge MEMCTRL_CLOCK_50 or negedge MEMCTRL_ResetInLow_In) begin
    if (!MEMCTRL_ResetInLow_In) begin
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
    end
  end

  assign MEMCTRL_MemoryData_OutBus = rdata_q;
  assign MEMCTRL_Ready_Out         = ready_q;
  assign MEMCTRL_Fault_Out         = fault_q;
  assign MEMCTRL_Busy_Out          = busy_q;
  assign MEMCTRL_MemAddr_OutBus    = waddr_q;
  assign MEMCTRL_MemWrData_OutBus  = wdata_q;
  assign MEMCTRL_MemWrEn_Out       = wren_q;
  assign MEMCTRL_MemRdEn_Out       = rden_q;

`ifdef MEMCTRL_ACCESS_COUNT_EN
  logic [15:0] acc_cnt_q;

  // Counts in the DONE cycle of successful accesses only
  always_ff @(posedge MEMCTRL_CLOCK_50 or negedge MEMCTRL_ResetInLow_In) begin
    if (!MEMCTRL_ResetInLow_In) begin
      acc_cnt_q <= '0;
    end else if (ready_q && !fault_q && (acc_cnt_q != 16'hFFFF)) begin
      acc_cnt_q <= acc_cnt_q + 16'd1;
    end
  end

  assign MEMCTRL_AccessCount_OutBus = acc_cnt_q;
`endif

endmodule

// File: tb/tb_sc_mem_access_ctrl.sv
// Bench for sc_mem_access_ctrl: two instances (1 and 3 wait states) driven in parallel,
// each with its own RAM, checked every cycle against a transaction-level model.
module tb_sc_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr, wd;
  logic        rd, wr;

  logic [31:0] mdata [2];
  logic        ready [2];
  logic        fault [2];
  logic        busy  [2];
  logic [9:0]  maddr [2];
  logic [31:0] mwd   [2];
  logic        wren  [2];
  logic        rden  [2];
  logic [31:0] rdq_a, rdq_b;
  logic [31:0] ram_a [1024];
  logic [31:0] ram_b [1024];
`ifdef MEMCTRL_ACCESS_COUNT_EN
  logic [15:0] acnt [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sc_mem_access_ctrl #(.DATAWIDTH_BUS(32), .ADDRWIDTH_MEM(10), .WAIT_STATES(1)) u_w1 (
    .MEMCTRL_CLOCK_50          (clk),
    .MEMCTRL_ResetInLow_In     (rst_n),
    .MEMCTRL_Address_InBus     (addr),
    .MEMCTRL_WriteData_InBus   (wd),
    .MEMCTRL_Read_In           (rd),
    .MEMCTRL_Write_In          (wr),
    .MEMCTRL_MemoryData_OutBus (mdata[0]),
    .MEMCTRL_Ready_Out         (ready[0]),
    .MEMCTRL_Fault_Out         (fault[0]),
    .MEMCTRL_Busy_Out          (busy[0]),
    .MEMCTRL_MemAddr_OutBus    (maddr[0]),
    .MEMCTRL_MemWrData_OutBus  (mwd[0]),
    .MEMCTRL_MemWrEn_Out       (wren[0]),
    .MEMCTRL_MemRdEn_Out       (rden[0]),
`ifdef MEMCTRL_ACCESS_COUNT_EN
    .MEMCTRL_AccessCount_OutBus(acnt[0]),
`endif
    .MEMCTRL_MemRdData_InBus   (rdq_a)
  );

  sc_mem_access_ctrl #(.DATAWIDTH_BUS(32), .ADDRWIDTH_MEM(10), .WAIT_STATES(3)) u_w3 (
    .MEMCTRL_CLOCK_50          (clk),
    .MEMCTRL_ResetInLow_In     (rst_n),
    .MEMCTRL_Address_InBus     (addr),
    .MEMCTRL_WriteData_InBus   (wd),
    .MEMCTRL_Read_In           (rd),
    .MEMCTRL_Write_In          (wr),
    .MEMCTRL_MemoryData_OutBus (mdata[1]),
    .MEMCTRL_Ready_Out         (ready[1]),
    .MEMCTRL_Fault_Out         (fault[1]),
    .MEMCTRL_Busy_Out          (busy[1]),
    .MEMCTRL_MemAddr_OutBus    (maddr[1]),
    .MEMCTRL_MemWrData_OutBus  (mwd[1]),
    .MEMCTRL_MemWrEn_Out       (wren[1]),
    .MEMCTRL_MemRdEn_Out       (rden[1]),
`ifdef MEMCTRL_ACCESS_COUNT_EN
    .MEMCTRL_AccessCount_OutBus(acnt[1]),
`endif
    .MEMCTRL_MemRdData_InBus   (rdq_b)
  );

  // Synchronous single-port RAMs, never reset
  always @(posedge clk) begin
    if (wren[0]) ram_a[maddr[0]] <= mwd[0];
    if (rden[0]) rdq_a <= ram_a[maddr[0]];
    if (wren[1]) ram_b[maddr[1]] <= mwd[1];
    if (rden[1]) rdq_b <= ram_b[maddr[1]];
  end

  // Transaction-level model: each accepted request is timed by k = cycles since acceptance
  bit [31:0] mem [2][1024];
  bit        act [2];
  int        k   [2];
  bit        mf  [2];
  bit        mw  [2];
  bit [9:0]  ma  [2];
  bit [31:0] md  [2];
  bit [31:0] erd [2];
  int        ecnt[2];

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int ready_cycle(input int i);
    return mf[i] ? 1 : wait_of(i) + 2;
  endfunction

  initial begin
    for (int j = 0; j < 1024; j++) begin
      ram_a[j] = 32'hA500_0000 | j;
      ram_b[j] = 32'hA500_0000 | j;
      mem[0][j] = 32'hA500_0000 | j;
      mem[1][j] = 32'hA500_0000 | j;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0; k[i] = 0; mf[i] = 1'b0; mw[i] = 1'b0;
        ma[i] = '0; md[i] = '0; erd[i] = '0; ecnt[i] = 0;
      end else if (act[i]) begin
        if (!mf[i] && mw[i] && k[i] == 1) mem[i][ma[i]] = md[i];
        if (k[i] == ready_cycle(i) && !mf[i] && ecnt[i] < 65535) ecnt[i]++;
        if (k[i] > ready_cycle(i)) begin
          if (!(rd || wr)) act[i] = 1'b0;
        end else begin
          k[i]++;
        end
        if (act[i] && !mf[i] && !mw[i] && k[i] == ready_cycle(i)) erd[i] = mem[i][ma[i]];
      end else if (rd || wr) begin
        act[i] = 1'b1;
        k[i]   = 1;
        mw[i]  = wr;
        mf[i]  = (addr % 4 != 0) || (addr >= 32'd4096);
        if (!mf[i]) begin
          ma[i] = 10'(addr / 4);
          md[i] = wd;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      rdy = act[i] && (k[i] == ready_cycle(i));
      chk($sformatf("busy%0d", i),  {31'b0, busy[i]},  {31'b0, act[i]});
      chk($sformatf("ready%0d", i), {31'b0, ready[i]}, {31'b0, rdy});
      chk($sformatf("fault%0d", i), {31'b0, fault[i]}, {31'b0, rdy && mf[i]});
      chk($sformatf("wren%0d", i),  {31'b0, wren[i]},
          {31'b0, act[i] && !mf[i] && mw[i] && k[i] == 1});
      chk($sformatf("rden%0d", i),  {31'b0, rden[i]},
          {31'b0, act[i] && !mf[i] && !mw[i] && k[i] == 1});
      chk($sformatf("maddr%0d", i), {22'b0, maddr[i]}, {22'b0, ma[i]});
      chk($sformatf("mwd%0d", i),   mwd[i],   md[i]);
      chk($sformatf("mdata%0d", i), mdata[i], erd[i]);
`ifdef MEMCTRL_ACCESS_COUNT_EN
      chk($sformatf("acnt%0d", i),  {16'b0, acnt[i]}, 32'(ecnt[i]));
`endif
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int nrd, rdy_at, n;
    logic [31:0] bad_addr [2];
    bad_addr[0] = 32'h13;
    bad_addr[1] = 32'h1000;
    rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("t1_busy0", {31'b0, busy[0]}, 32'd0);
    chk("t1_mdata1", mdata[1], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_busy_after", {31'b0, busy[1]}, 32'd0);

    // Write 0xDEADBEEF to byte address 0x10
    wr = 1'b1; addr = 32'h10; wd = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_wren_c1", {31'b0, wren[0]}, 32'd1);
    chk("t2_maddr_c1", {22'b0, maddr[0]}, 32'd4);
    chk("t2_mwd_c1", mwd[0], 32'hDEADBEEF);
    addr = 32'hFFFF_FFF0; wd = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("t2_wren_c2", {31'b0, wren[0]}, 32'd0);
    chk("t2_ready_c2", {31'b0, ready[0]}, 32'd0);
    @(negedge clk);
    chk("t2_ready_c3", {31'b0, ready[0]}, 32'd1);
    chk("t2_fault_c3", {31'b0, fault[0]}, 32'd0);
    chk("t2_mwd_c3", mwd[0], 32'hDEADBEEF);
    wr = 1'b0;
    wait_idle();

    // Read it back
    rd = 1'b1; addr = 32'h10;
    @(negedge clk);
    chk("t3_rden_c1", {31'b0, rden[0]}, 32'd1);
    @(negedge clk);
    chk("t3_rden_c2", {31'b0, rden[0]}, 32'd0);
    @(negedge clk);
    chk("t3_ready_c3", {31'b0, ready[0]}, 32'd1);
    chk("t3_mdata_c3", mdata[0], 32'hDEADBEEF);
    rd = 1'b0;
    wait_idle();
    chk("t3_mdata_w3", mdata[1], 32'hDEADBEEF);

    // Faulting addresses
    for (int j = 0; j < 2; j++) begin
      rd = 1'b1; addr = bad_addr[j];
      @(negedge clk);
      chk("t4_ready", {31'b0, ready[0]}, 32'd1);
      chk("t4_fault", {31'b0, fault[1]}, 32'd1);
      chk("t4_rden", {31'b0, rden[0]}, 32'd0);
      rd = 1'b0;
      wait_idle();
      chk("t4_mdata", mdata[0], 32'hDEADBEEF);
    end

    // Request held for 12 cycles on the 3-wait-state instance
    rd = 1'b1; addr = 32'h10; nrd = 0; rdy_at = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      nrd += int'(rden[1]);
      if (ready[1]) rdy_at = c;
      if (c == 12) begin
        chk("t5_busy_c12", {31'b0, busy[1]}, 32'd1);
        rd = 1'b0;
      end
    end
    chk("t5_rden_count", 32'(nrd), 32'd1);
    chk("t5_ready_at", 32'(rdy_at), 32'd5);
    @(negedge clk);
    chk("t5_busy_c13", {31'b0, busy[1]}, 32'd0);
    wait_idle();

    // Reset while the write strobe is high: the RAM must not be written
    wr = 1'b1; addr = 32'h20; wd = 32'h1234_5678;
    @(negedge clk);
    chk("t6_wren_c1", {31'b0, wren[1]}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_wren_async", {31'b0, wren[1]}, 32'd0);
    chk("t6_busy_async", {31'b0, busy[1]}, 32'd0);
    chk("t6_wren0_async", {31'b0, wren[0]}, 32'd0);
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd = 1'b1; addr = 32'h20;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[1] && n < 20);
    chk("t6_ready_at", 32'(n), 32'd5);
    chk("t6_mdata_w3", mdata[1], 32'hA500_0008);
    chk("t6_mdata_w1", mdata[0], 32'hA500_0008);
    rd = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
